// File: rtl/fetch_stage_if.sv
// Instruction-memory read port between the fetch stage and a synchronous,
// one-cycle-latency instruction memory.
interface fetch_stage_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              imem_req;
  logic [AWIDTH-1:0] imem_addr;
  logic [DWIDTH-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, instruction-memory request, stall hold
// buffer and the IF/ID pipeline register.
//
// state | meaning
// BOOT  | first cycle after reset, no fetch request
// RUN   | fetching one instruction per cycle unless stalled
module fetch_stage #(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
  parameter logic [DWIDTH-1:0] NOP      = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_if,
  input  logic               ifid_wren,
  input  logic               ifid_flush,
  input  logic               e_redirect,
  input  logic [AWIDTH-1:0]  e_target,
  fetch_stage_if.master      imem,
  output logic [AWIDTH-1:0]  f_pc,
  output logic [DWIDTH-1:0]  f_insn,
  output logic               f_valid,
  output logic [AWIDTH-1:0]  d_pc,
  output logic [DWIDTH-1:0]  d_insn,
  output logic               d_valid,
  output logic [31:0]        fetch_count
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              req;
  logic [AWIDTH-1:0] pc_q;
  logic [AWIDTH-1:0] redirect_pc;
  logic              resp_v_q;
  logic [AWIDTH-1:0] resp_pc_q;
  logic              hold_v;
  logic [AWIDTH-1:0] hold_pc;
  logic [DWIDTH-1:0] hold_insn;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    req = 1'b0;
    if (state_q == RUN) req = ~stall_if;
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign redirect_pc    = e_target & ~AWIDTH'(3);

  // A redirect still lets the request go out; its response is squashed here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= BASEADDR;
      resp_v_q  <= 1'b0;
      resp_pc_q <= BASEADDR;
    end else begin
      resp_v_q <= req & ~e_redirect;
      if (req) resp_pc_q <= pc_q;
      if (e_redirect) pc_q <= redirect_pc;
      else if (req)   pc_q <= pc_q + AWIDTH'(4);
    end
  end

  // The memory never re-presents data, so a response landing during a stall
  // is parked here until the stall releases.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_v    <= 1'b0;
      hold_pc   <= BASEADDR;
      hold_insn <= NOP;
    end else if (e_redirect || !stall_if) begin
      hold_v <= 1'b0;
    end else if (resp_v_q && !hold_v) begin
      hold_v    <= 1'b1;
      hold_pc   <= resp_pc_q;
      hold_insn <= imem.imem_rdata;
    end
  end

  always_comb begin
    f_valid = 1'b0;
    f_pc    = pc_q;
    f_insn  = NOP;
    if (hold_v) begin
      f_valid = 1'b1;
      f_pc    = hold_pc;
      f_insn  = hold_insn;
    end else if (resp_v_q) begin
      f_valid = 1'b1;
      f_pc    = resp_pc_q;
      f_insn  = imem.imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_pc        <= BASEADDR;
      d_insn      <= NOP;
      d_valid     <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      if (ifid_flush) begin
        d_insn  <= NOP;
        d_valid <= 1'b0;
      end else if (ifid_wren) begin
        d_pc    <= f_pc;
        d_insn  <= f_insn;
        d_valid <= f_valid;
      end
      if (ifid_wren && !ifid_flush && f_valid) fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID contents are queued by the
// stimulus and popped by a monitor each time IF/ID loads a live instruction.
module tb_fetch_stage;
  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [31:0] NOPI = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, stall_if, ifid_wren, ifid_flush, e_redirect;
  logic [31:0] e_target;
  logic [31:0] f_pc, f_insn, d_pc, d_insn, fetch_count;
  logic        f_valid, d_valid;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  fetch_stage_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_if    (stall_if),
    .ifid_wren   (ifid_wren),
    .ifid_flush  (ifid_flush),
    .e_redirect  (e_redirect),
    .e_target    (e_target),
    .imem        (bus),
    .f_pc        (f_pc),
    .f_insn      (f_insn),
    .f_valid     (f_valid),
    .d_pc        (d_pc),
    .d_insn      (d_insn),
    .d_valid     (d_valid),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {8'hAB, a[23:0]};
  endfunction

  // Synchronous memory model; garbage when not requested.
  always @(posedge clk)
    bus.imem_rdata <= bus.imem_req ? mem(bus.imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: an IF/ID load is known from the bench's own controls.
  initial begin
    logic        ld;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      ld = rst_n && ifid_wren && !ifid_flush;
      @(negedge clk);
      if (ld && d_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=%h required=none", d_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_d_pc", d_pc, e);
          chk("sb_d_insn", d_insn, mem(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic start(input logic rn, st, wr, fl, rd, input logic [31:0] tg);
    @(posedge clk);
    #1;
    rst_n = rn; stall_if = st; ifid_wren = wr; ifid_flush = fl;
    e_redirect = rd; e_target = tg;
  endtask

  task automatic run();
    start(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  // Ends the current cycle, holds reset for one edge, leaves us in cycle 0.
  task automatic do_reset();
    start(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    run();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset();
    @(negedge clk);
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_imem_addr", bus.imem_addr, BASE);
    chk("rst_f_valid", 32'(f_valid), 32'd0);
    chk("rst_f_insn", f_insn, NOPI);
    chk("rst_f_pc", f_pc, BASE);
    chk("rst_d_pc", d_pc, BASE);
    chk("rst_d_insn", d_insn, NOPI);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_fetch_count", fetch_count, 32'd0);
  endtask

  task automatic push(input logic [31:0] off);
    exp_q.push_back(BASE + off);
  endtask

  initial begin
    rst_n = 1'b0; stall_if = 1'b0; ifid_wren = 1'b1; ifid_flush = 1'b0;
    e_redirect = 1'b0; e_target = 32'h0;

    // A: free-running start-up
    do_reset();
    check_reset();
    push(0); push(4); push(8); push(12);
    run(); @(negedge clk);
    chk("a_c1_req", 32'(bus.imem_req), 32'd1);
    chk("a_c1_addr", bus.imem_addr, BASE);
    run(); @(negedge clk);
    chk("a_c2_f_valid", 32'(f_valid), 32'd1);
    chk("a_c2_f_pc", f_pc, BASE);
    chk("a_c2_f_insn", f_insn, mem(BASE));
    run(); @(negedge clk);
    chk("a_c3_d_valid", 32'(d_valid), 32'd1);
    run(); run(); @(negedge clk);
    chk("a_c5_count", fetch_count, 32'd3);

    // B: one-cycle stall while 0x08 is in fetch
    do_reset();
    check_reset();
    push(0); push(4); push(8); push(12); push(16);
    run(); run(); run();
    start(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); @(negedge clk);
    chk("b_stall_req", 32'(bus.imem_req), 32'd0);
    chk("b_stall_addr", bus.imem_addr, BASE + 32'hC);
    chk("b_stall_f_pc", f_pc, BASE + 32'h8);
    run(); @(negedge clk);
    chk("b_hold_v", 32'(dut.hold_v), 32'd1);
    chk("b_rel_f_pc", f_pc, BASE + 32'h8);
    chk("b_rel_f_valid", 32'(f_valid), 32'd1);
    chk("b_rel_req", 32'(bus.imem_req), 32'd1);
    chk("b_rel_d_pc", d_pc, BASE + 32'h4);
    chk("b_rel_count", fetch_count, 32'd2);
    run(); run(); @(negedge clk);
    chk("b_c7_count", fetch_count, 32'd4);

    // C: three-cycle stall
    do_reset();
    check_reset();
    push(0); push(4); push(8); push(12); push(16);
    run(); run(); run();
    start(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    start(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    start(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); @(negedge clk);
    chk("c_c6_req", 32'(bus.imem_req), 32'd0);
    chk("c_c6_f_pc", f_pc, BASE + 32'h8);
    chk("c_c6_f_valid", 32'(f_valid), 32'd1);
    chk("c_c6_d_pc", d_pc, BASE + 32'h4);
    chk("c_c6_count", fetch_count, 32'd2);
    run(); run(); @(negedge clk);
    chk("c_c8_count", fetch_count, 32'd3);
    run(); @(negedge clk);
    chk("c_c9_count", fetch_count, 32'd4);

    // D: redirect to an unaligned target, IF/ID flushed alongside
    do_reset();
    check_reset();
    push(0); push(4); push(32'h40); push(32'h44);
    run(); run(); run();
    start(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0100_0042); @(negedge clk);
    run(); @(negedge clk);
    chk("d_t1_f_valid", 32'(f_valid), 32'd0);
    chk("d_t1_addr", bus.imem_addr, BASE + 32'h40);
    chk("d_t1_req", 32'(bus.imem_req), 32'd1);
    chk("d_t1_d_valid", 32'(d_valid), 32'd0);
    chk("d_t1_d_insn", d_insn, NOPI);
    chk("d_t1_d_pc", d_pc, BASE + 32'h4);
    chk("d_t1_count", fetch_count, 32'd2);
    run(); @(negedge clk);
    chk("d_t2_f_pc", f_pc, BASE + 32'h40);
    chk("d_t2_f_valid", 32'(f_valid), 32'd1);
    run(); @(negedge clk);
    chk("d_t3_d_pc", d_pc, BASE + 32'h40);
    chk("d_t3_count", fetch_count, 32'd3);

    // E: redirect and stall together while the hold buffer is full
    do_reset();
    check_reset();
    push(0); push(4); push(32'h80); push(32'h84);
    run(); run(); run();
    start(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    start(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0100_0080); @(negedge clk);
    chk("e_t_hold_v", 32'(dut.hold_v), 32'd1);
    run(); @(negedge clk);
    chk("e_t1_hold_v", 32'(dut.hold_v), 32'd0);
    chk("e_t1_f_valid", 32'(f_valid), 32'd0);
    chk("e_t1_addr", bus.imem_addr, BASE + 32'h80);
    chk("e_t1_d_valid", 32'(d_valid), 32'd0);
    run(); @(negedge clk);
    chk("e_t2_f_pc", f_pc, BASE + 32'h80);
    run(); @(negedge clk);
    chk("e_t3_d_pc", d_pc, BASE + 32'h80);
    chk("e_t3_count", fetch_count, 32'd3);

    // F: reset during a stall with the hold buffer full
    do_reset();
    check_reset();
    push(0); push(4); push(0); push(4);
    run(); run(); run();
    start(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    start(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); @(negedge clk);
    chk("f_pre_hold_v", 32'(dut.hold_v), 32'd1);
    run();
    check_reset();
    chk("f_hold_v", 32'(dut.hold_v), 32'd0);
    chk("f_resp_v", 32'(dut.resp_v_q), 32'd0);
    run(); @(negedge clk);
    chk("f_c1_addr", bus.imem_addr, BASE);
    chk("f_c1_req", 32'(bus.imem_req), 32'd1);
    run(); run(); @(negedge clk);
    chk("f_c3_d_valid", 32'(d_valid), 32'd1);
    chk("f_c3_d_pc", d_pc, BASE);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
